// File: rtl/core_pkg.sv
// core_pkg: shared state encoding, frame defaults and result record for core_sequencer
package core_pkg;
    typedef enum logic [1:0] {LOAD, STREAM, WAIT, DONE} state_t;
    localparam int NUM_PIXELS_DEF     = 784;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    localparam int DIGIT_WIDTH_DEF    = 4;
    typedef struct packed {
        logic [DIGIT_WIDTH_DEF-1:0] digit;
        logic                       timeout;
    } result_t;
endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: single-port pixel store with synchronous write and one-cycle registered read
module frame_buffer
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = NUM_PIXELS_DEF,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    assign o_rdata = r_rdata;
    // Pixel storage has no reset so a frame survives rst untouched
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    // Read data idles at zero whenever no read is issued
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= i_re ? r_mem[i_addr] : '0;
    end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: buffers one host frame, replays it to the core as one burst, returns digit or timeout
module core_sequencer
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DIGIT_WIDTH    = 4,
    parameter int NUM_PIXELS     = NUM_PIXELS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_pixel,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DIGIT_WIDTH-1:0] m_digit,
    output logic                   m_timeout,
    output logic                   core_i_valid,
    output logic [DATA_WIDTH-1:0]  core_pixel,
    input  logic                   core_o_valid,
    input  logic [DIGIT_WIDTH-1:0] core_digit,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frame_count
);
    localparam int IW = $clog2(NUM_PIXELS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [TW-1:0]          r_tcnt;
    logic                   r_tail;
    logic                   r_core_valid;
    logic [DIGIT_WIDTH-1:0] r_digit;
    logic                   r_timeout;
    logic [CNT_WIDTH-1:0]   r_fc;
    logic                   w_accept;
    logic                   w_rd;
    logic                   w_last;
    logic                   w_expire;
    assign s_ready      = r_state == LOAD;
    assign m_valid      = r_state == DONE;
    assign busy         = r_state != LOAD;
    assign w_accept     = s_valid && s_ready;
    assign w_rd         = r_state == STREAM && !r_tail;
    assign w_last       = r_idx == IW'(NUM_PIXELS - 1);
    assign w_expire     = r_tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign core_i_valid = r_core_valid;
    assign m_digit      = r_digit;
    assign m_timeout    = r_timeout;
    assign frame_count  = r_fc;
    frame_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (NUM_PIXELS),
        .AW        (IW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept),
        .i_re   (w_rd),
        .i_addr (r_idx),
        .i_wdata(s_pixel),
        .o_rdata(core_pixel)
    );
    // Frame FSM; r_tail holds STREAM one extra cycle so WAIT starts after the last pixel leaves the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOAD;
            r_idx        <= '0;
            r_tcnt       <= '0;
            r_tail       <= 1'b0;
            r_core_valid <= 1'b0;
            r_digit      <= '0;
            r_timeout    <= 1'b0;
            r_fc         <= '0;
        end else begin
            r_core_valid <= w_rd;
            if (w_accept || w_rd) r_idx <= w_last ? '0 : r_idx + IW'(1);
            case (r_state)
                LOAD: if (w_accept && w_last) r_state <= STREAM;
                STREAM: begin
                    r_tail <= w_rd && w_last;
                    if (r_tail) r_state <= WAIT;
                end
                WAIT: begin
                    r_tcnt <= (core_o_valid || w_expire) ? '0 : r_tcnt + TW'(1);
                    if (core_o_valid || w_expire) begin
                        r_digit   <= core_o_valid ? core_digit : '0;
                        r_timeout <= !core_o_valid;
                        r_state   <= DONE;
                    end
                    if (core_o_valid) r_fc <= r_fc + CNT_WIDTH'(1);
                end
                DONE: if (m_ready) r_state <= LOAD;
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed frames against core_sequencer with pixel and result scoreboards
module tb_core_sequencer;
    import core_pkg::*;
    localparam int NP = NUM_PIXELS_DEF;
    localparam int TO = TIMEOUT_CYCLES_DEF;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_pixel = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_digit;
    logic        m_timeout;
    logic        core_i_valid;
    logic [7:0]  core_pixel;
    logic        core_o_valid = 1'b0;
    logic [3:0]  core_digit = '0;
    logic        busy;
    logic [15:0] frame_count;
    int          checks = 0;
    int          errors = 0;
    int          exp_fc = 0;
    bit          abort = 1'b1;
    logic [7:0]  pix_q[$];
    result_t     res_q[$];

    core_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_pixel     (s_pixel),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_digit     (m_digit),
        .m_timeout   (m_timeout),
        .core_i_valid(core_i_valid),
        .core_pixel  (core_pixel),
        .core_o_valid(core_o_valid),
        .core_digit  (core_digit),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Core-side monitor: every burst pixel must match the host order and bursts must be gap-free
    initial begin
        int  len = 0;
        bit  prev = 1'b0;
        forever begin
            @(negedge clk);
            if (abort) begin
                len  = 0;
                prev = 1'b0;
            end else begin
                if (core_i_valid) begin
                    len++;
                    if (pix_q.size() == 0) chk("pixel_unexpected", core_i_valid, 0);
                    else chk("core_pixel", core_pixel, pix_q.pop_front());
                end else if (prev) begin
                    chk("burst_len", len, NP);
                    chk("pixel_idle", core_pixel, 0);
                    len = 0;
                end
                prev = core_i_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_digit", m_digit, 0);
        chk("rst_m_timeout", m_timeout, 0);
        chk("rst_core_i_valid", core_i_valid, 0);
        chk("rst_core_pixel", core_pixel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
    endtask

    task automatic send_frame(input bit bursty);
        int         i = 0;
        int         guard = 0;
        logic [7:0] v;
        v = bursty ? 8'($urandom) : 8'(i);
        while (i < NP && guard < 20000) begin
            s_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
            s_pixel = v;
            if (s_valid && s_ready) begin
                pix_q.push_back(v);
                i++;
                v = bursty ? 8'($urandom) : 8'(i);
            end
            tick;
            guard++;
        end
        s_valid = 1'b0;
        chk("frame_loaded", i, NP);
        chk("s_ready_stream", s_ready, 0);
        chk("busy_stream", busy, 1);
        chk("ivalid_early", core_i_valid, 0);
        tick;
        chk("ivalid_first", core_i_valid, 1);
    endtask

    task automatic wait_burst_end;
        int k = 0;
        bit seen = 1'b0;
        while (k < 3000 && !(seen && !core_i_valid)) begin
            seen |= core_i_valid;
            tick;
            k++;
        end
        chk("burst_end_seen", 32'(seen && !core_i_valid), 1);
    endtask

    task automatic respond(input int delay, input logic [3:0] d);
        repeat (delay) tick;
        core_o_valid = 1'b1;
        core_digit   = d;
        res_q.push_back(result_t'{digit: d, timeout: 1'b0});
        exp_fc++;
        tick;
        core_o_valid = 1'b0;
        core_digit   = '0;
    endtask

    task automatic get_result(input int hold, input int exp_lat);
        int      k = 0;
        result_t r = '0;
        while (!m_valid && k < 6000) begin
            tick;
            k++;
        end
        chk("m_valid_seen", m_valid, 1);
        if (exp_lat >= 0) chk("done_latency", k, exp_lat);
        if (res_q.size() == 0) chk("result_unexpected", m_valid, 0);
        else begin
            r = res_q.pop_front();
            chk("m_digit", m_digit, r.digit);
            chk("m_timeout", m_timeout, r.timeout);
        end
        chk("frame_count", frame_count, exp_fc);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("hold_m_valid", m_valid, 1);
            chk("hold_m_digit", m_digit, r.digit);
            chk("hold_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("m_valid_after_ack", m_valid, 0);
        chk("s_ready_after_ack", s_ready, 1);
    endtask

    initial begin
        int k;
        tick;
        tick;
        check_reset;
        rst   = 1'b0;
        abort = 1'b0;
        // Basic frame, digit 7 twenty cycles after the last core pixel
        send_frame(1'b0);
        wait_burst_end;
        respond(19, 4'd7);
        get_result(0, 0);
        // Bursty host
        send_frame(1'b1);
        wait_burst_end;
        respond(5, 4'd2);
        get_result(0, 0);
        // Spurious core_o_valid in LOAD is ignored
        core_o_valid = 1'b1;
        core_digit   = 4'd9;
        tick;
        tick;
        core_o_valid = 1'b0;
        core_digit   = '0;
        chk("spur_m_valid", m_valid, 0);
        chk("spur_busy", busy, 0);
        chk("spur_frame_count", frame_count, exp_fc);
        chk("spur_s_ready", s_ready, 1);
        // Timeout: core never answers
        send_frame(1'b0);
        wait_burst_end;
        res_q.push_back(result_t'{digit: 4'd0, timeout: 1'b1});
        get_result(0, TO);
        // Backpressure on the result port
        send_frame(1'b0);
        wait_burst_end;
        respond(10, 4'd3);
        get_result(50, 0);
        // core_o_valid on the final timeout cycle wins
        send_frame(1'b0);
        wait_burst_end;
        respond(TO - 1, 4'd5);
        get_result(0, 0);
        // Reset in the middle of the core burst
        send_frame(1'b0);
        k = 1;
        for (int g = 0; g < 2000 && k < 400; g++) begin
            tick;
            if (core_i_valid) k++;
        end
        chk("reached_pixel_400", k, 400);
        rst   = 1'b1;
        abort = 1'b1;
        tick;
        check_reset;
        rst = 1'b0;
        pix_q.delete();
        res_q.delete();
        exp_fc = 0;
        tick;
        abort = 1'b0;
        send_frame(1'b0);
        wait_burst_end;
        respond(19, 4'd4);
        get_result(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Frame-level controller that sits between a host pixel stream and the MNIST accelerator core. Buffers one full image from a bursty valid/ready host interface, then replays it to the core as one contiguous i_valid burst. Waits for the core's o_valid with a timeout and returns the classified digit, or a timeout flag, on a valid/ready result port. Processes one frame at a time; the next frame is accepted only after the result is consumed.

Parameters:
DATA_WIDTH, 8, pixel width; matches the core's pixel port.
DIGIT_WIDTH, 4, width of the core's digit output.
NUM_PIXELS, 784, pixels per frame (28x28).
TIMEOUT_CYCLES, 4096, maximum cycles in WAIT before the frame is aborted.
CNT_WIDTH, 16, width of frame_count.

Ports:
clk  in  1  system clock; the single clock domain.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  host pixel valid.
s_ready  out  1  sequencer can accept a pixel.
s_pixel  in  DATA_WIDTH  host pixel data.
m_valid  out  1  result valid.
m_ready  in  1  host accepts result.
m_digit  out  DIGIT_WIDTH  classified digit; 0 on timeout.
m_timeout  out  1  result is a timeout abort.
core_i_valid  out  1  drives core i_valid.
core_pixel  out  DATA_WIDTH  drives core pixel.
core_o_valid  in  1  core o_valid.
core_digit  in  DIGIT_WIDTH  core digit.
busy  out  1  high in any state other than LOAD.
frame_count  out  CNT_WIDTH  number of frames completed with a valid digit; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset (rst=1 at a clock edge): state=LOAD, pixel index=0, timeout counter=0.
- Output reset values: s_ready=1, m_valid=0, m_digit=0, m_timeout=0, core_i_valid=0, core_pixel=0, busy=0, frame_count=0.
- Buffer contents are not cleared by reset.
- Reset mid-frame abandons the frame with no result produced. The core shares rst, so both restart together.
- LOAD: s_ready=1.
  - On s_valid&&s_ready, write s_pixel to buffer[idx] and increment idx.
  - When the pixel at idx=NUM_PIXELS-1 is accepted: idx<=0 and go to STREAM. s_ready is 0 from the next cycle.
- STREAM: core_i_valid and core_pixel are registered outputs.
  - Each cycle, core_i_valid<=1 and core_pixel<=buffer[idx]; idx increments.
  - The burst is exactly NUM_PIXELS consecutive cycles with no gaps.
  - The first core_i_valid appears 1 cycle after entering STREAM, i.e. 2 cycles after the last host pixel is accepted.
  - After the final pixel is issued, go to WAIT. core_i_valid=0 and core_pixel=0 from the following cycle.
- WAIT: the timeout counter increments each cycle from 0.
  - core_o_valid=1: capture core_digit into m_digit, m_timeout<=0, frame_count+1, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without core_o_valid: m_digit<=0, m_timeout<=1, frame_count unchanged, go to DONE.
  - If core_o_valid arrives in the same cycle as the timeout, core_o_valid wins.
- DONE: m_valid=1; m_digit and m_timeout are held stable until the handshake.
  - On m_valid&&m_ready, go to LOAD. The next cycle has m_valid=0 and s_ready=1.
- core_o_valid in any state other than WAIT is ignored (no capture, no count).
- s_valid while s_ready=0 is not accepted; the host must hold its data.
- m_ready while m_valid=0 has no effect.
- The index counter is $clog2(NUM_PIXELS) bits wide. The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide. Both counters reset to 0 on every state entry.

Decomposition:
- Shared package core_pkg holds:
  - a state enum {LOAD, STREAM, WAIT, DONE};
  - default constants NUM_PIXELS=784 and TIMEOUT_CYCLES=4096;
  - a result struct {digit, timeout}.
- One sub-module, frame_buffer: single-port NUM_PIXELS x DATA_WIDTH array with synchronous write and registered read (1-cycle latency).
  - The STREAM read address leads core_pixel by one cycle.
  - The sequencer FSM plus counters stays in core_sequencer.

Test Plan:
- Basic frame: host sends pixels 0..783 with pixel value = idx mod 256, no gaps; core model asserts o_valid with digit=7 20 cycles after the last i_valid, m_ready=1.
  -> core sees 784 contiguous i_valid with matching values; m_valid=1 with m_digit=7 and m_timeout=0; frame_count=1.
- Bursty host: s_valid toggles randomly at 50% duty.
  -> core burst is still 784 gap-free cycles and pixel order is preserved.
- Timeout: core model never asserts o_valid.
  -> DONE entered exactly TIMEOUT_CYCLES cycles after WAIT entry; m_timeout=1, m_digit=0, frame_count unchanged.
- Backpressure: m_ready held 0 for 50 cycles with digit=3.
  -> m_valid stays 1 and m_digit stays 3; s_ready=0 throughout; s_ready=1 the cycle after m_ready=1.
- Spurious and simultaneous events:
  - core_o_valid=1 pulsed during LOAD -> ignored.
  - core_o_valid coinciding with the last timeout cycle -> m_timeout=0 with the captured digit.
- Reset mid-STREAM at pixel 400.
  -> all outputs reach their reset values the next cycle; a new full frame then completes normally with frame_count=1.
